// File: rtl/uart_rx_monitor_if.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_monitor_if                                            |
// | Purpose  : Receive-byte stream interface between the UART RX monitor     |
// |            FIFO and its consumer (bench or host adapter).                |
// | Signals  : out_data_o  [7:0] FIFO head byte         (master -> slave)    |
// |            out_valid_o       FIFO non-empty          (master -> slave)   |
// |            out_ready_i       consumer accepts head   (slave  -> master)  |
// | Modports : master (monitor side), slave (consumer side)                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface uart_rx_monitor_if;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;

  modport master (
    output out_data_o,
    output out_valid_o,
    input  out_ready_i
  );

  modport slave (
    input  out_data_o,
    input  out_valid_o,
    output out_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_monitor.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_monitor                                               |
// | Purpose  : 8N1 UART receiver for the SoC TX pin. Deserialises bytes into |
// |            a receive FIFO drained by valid/ready, flags framing errors   |
// |            and FIFO overflow, and counts accepted newline (0x0A) bytes.  |
// | Ports    : clk, rst (async, active-high)                                 |
// |            rx_i              serial input, idles high, asynchronous      |
// |            out_if (master)   out_data_o / out_valid_o / out_ready_i      |
// |            fifo_count_o      FIFO occupancy                              |
// |            busy_o            frame in progress                           |
// |            frame_err_o       pulse on bad stop bit                       |
// |            frame_err_cnt_o   saturating framing-error count              |
// |            overflow_o        sticky dropped-byte flag                    |
// |            newline_cnt_o     wrapping count of accepted 0x0A bytes       |
// |            clear_i           clears overflow and both counters           |
// | Option   : `define UART_RX_MONITOR_PARITY_EN adds a parity bit between   |
// |            data and stop (parameter PARITY_ODD, outputs parity_err_o and |
// |            parity_err_cnt_o).                                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_monitor #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 3125000,
  parameter int FIFO_DEPTH  = 16
`ifdef UART_RX_MONITOR_PARITY_EN
  ,
  parameter bit PARITY_ODD  = 1'b0
`endif
) (
  input  wire                          clk,
  input  wire                          rst,
  input  wire                          rx_i,
  uart_rx_monitor_if.master            out_if,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic                         busy_o,
  output logic                         frame_err_o,
  output logic [7:0]                   frame_err_cnt_o,
  output logic                         overflow_o,
  output logic [15:0]                  newline_cnt_o,
`ifdef UART_RX_MONITOR_PARITY_EN
  output logic                         parity_err_o,
  output logic [7:0]                   parity_err_cnt_o,
`endif
  input  wire                          clear_i
);

  // CLKS_PER_BIT must be >= 8 and FIFO_DEPTH a power of two >= 2.
  localparam int C_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int C_CNT_W        = $clog2(C_CLKS_PER_BIT);
  localparam int C_PTR_W        = $clog2(FIFO_DEPTH);
  localparam int C_OCC_W        = C_PTR_W + 1;

  localparam logic [C_CNT_W-1:0] C_BIT_RELOAD  = C_CNT_W'(C_CLKS_PER_BIT - 1);
  localparam logic [C_CNT_W-1:0] C_HALF_RELOAD = C_CNT_W'(C_CLKS_PER_BIT / 2 - 1);
  localparam logic [C_OCC_W-1:0] C_FIFO_FULL   = C_OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_MONITOR_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- sync ---
  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic w_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign w_fall = rx_prev_q & ~rx_s_q;

  // ----------------------------------------------------------------- FSM ---
  state_t             state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               w_sample;
  logic               w_push;
  logic               w_frame_err;
`ifdef UART_RX_MONITOR_PARITY_EN
  logic               par_q, par_d;
  logic               w_parity_err;
  logic               w_par_bad;

  // Received data XOR parity bit is 0 for even parity, 1 for odd parity.
  assign w_par_bad = (((^shift_q) ^ par_q) != PARITY_ODD);
`endif

  assign w_sample = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_MONITOR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef UART_RX_MONITOR_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
    par_d        = par_q;
    w_parity_err = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Half-bit load puts every later sample near the bit centre.
        if (w_fall) begin
          cnt_d   = C_HALF_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_sample) begin
          if (!rx_s_q) begin
            cnt_d   = C_BIT_RELOAD;
            idx_d   = 3'd0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (w_sample) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = C_BIT_RELOAD;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_MONITOR_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef UART_RX_MONITOR_PARITY_EN
      S_PARITY: begin
        if (w_sample) begin
          par_d   = rx_s_q;
          cnt_d   = C_BIT_RELOAD;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid-stop so a start edge at the end of the stop bit
        // is seen from IDLE (back-to-back frames).
        if (w_sample) begin
          state_d = S_IDLE;
          if (rx_s_q) begin
            w_push = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
`ifdef UART_RX_MONITOR_PARITY_EN
          w_parity_err = w_par_bad;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FIFO ---
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [C_OCC_W-1:0] count_q;
  logic               w_valid, w_pop, w_full, w_write, w_ovf, w_newline;

  assign w_valid   = (count_q != '0);
  assign w_pop     = w_valid & out_if.out_ready_i;
  assign w_full    = (count_q == C_FIFO_FULL);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_write   = w_push & (~w_full | w_pop);
  assign w_ovf     = w_push & w_full & ~w_pop;
  assign w_newline = w_write & (shift_q == 8'h0A);

  always_ff @(posedge clk) begin
    if (w_write) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_write) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // -------------------------------------------------------------- status ---
  // Where an event meets clear_i in one cycle, the event survives the clear.
  logic [7:0]  fe_cnt_q;
  logic        ovf_q;
  logic [15:0] nl_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_cnt_q <= '0;
      ovf_q    <= 1'b0;
      nl_cnt_q <= '0;
    end else if (clear_i) begin
      fe_cnt_q <= {7'd0, w_frame_err};
      ovf_q    <= w_ovf;
      nl_cnt_q <= {15'd0, w_newline};
    end else begin
      if (w_frame_err && (fe_cnt_q != 8'hFF)) begin
        fe_cnt_q <= fe_cnt_q + 8'd1;
      end
      if (w_ovf) begin
        ovf_q <= 1'b1;
      end
      if (w_newline) begin
        nl_cnt_q <= nl_cnt_q + 16'd1;
      end
    end
  end

`ifdef UART_RX_MONITOR_PARITY_EN
  logic [7:0] pe_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_cnt_q <= '0;
    end else if (clear_i) begin
      pe_cnt_q <= {7'd0, w_parity_err};
    end else if (w_parity_err && (pe_cnt_q != 8'hFF)) begin
      pe_cnt_q <= pe_cnt_q + 8'd1;
    end
  end

  assign parity_err_o     = w_parity_err;
  assign parity_err_cnt_o = pe_cnt_q;
`endif

  // ------------------------------------------------------------- outputs ---
  // Head is masked while empty so the output reads 0 out of reset.
  assign out_if.out_valid_o = w_valid;
  assign out_if.out_data_o  = w_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count_o       = count_q;
  assign busy_o             = (state_q != S_IDLE);
  assign frame_err_o        = w_frame_err;
  assign frame_err_cnt_o    = fe_cnt_q;
  assign overflow_o         = ovf_q;
  assign newline_cnt_o      = nl_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_monitor.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_monitor                                            |
// | Purpose  : Directed self-checking bench for uart_rx_monitor at           |
// |            100 MHz / 3.125 Mbaud (32 clocks per bit).                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_rx_monitor;

  localparam int C_CPB = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_i;
  logic        clear_i;
  logic [4:0]  fifo_count;
  logic        busy;
  logic        frame_err;
  logic [7:0]  frame_err_cnt;
  logic        overflow;
  logic [15:0] newline_cnt;
`ifdef UART_RX_MONITOR_PARITY_EN
  logic        parity_err;
  logic [7:0]  parity_err_cnt;
`endif

  uart_rx_monitor_if u_if ();

  uart_rx_monitor #(
    .CLK_FREQ_HZ (100000000),
    .BAUD_RATE   (3125000),
    .FIFO_DEPTH  (16)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .rx_i             (rx_i),
    .out_if           (u_if),
    .fifo_count_o     (fifo_count),
    .busy_o           (busy),
    .frame_err_o      (frame_err),
    .frame_err_cnt_o  (frame_err_cnt),
    .overflow_o       (overflow),
    .newline_cnt_o    (newline_cnt),
`ifdef UART_RX_MONITOR_PARITY_EN
    .parity_err_o     (parity_err),
    .parity_err_cnt_o (parity_err_cnt),
`endif
    .clear_i          (clear_i)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter and passive observers of pops / pulses.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  popq[$];
  int unsigned fe_pulses  = 0;
  int unsigned rise_cyc   = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (u_if.out_valid_o && u_if.out_ready_i) popq.push_back(u_if.out_data_o);
    if (frame_err) fe_pulses++;
    if (u_if.out_valid_o && !prev_valid) rise_cyc = cyc;
    prev_valid = u_if.out_valid_o;
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each helper starts and ends 1 ns after a rising edge.
  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (C_CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_MONITOR_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_bit);
  endtask

`ifdef UART_RX_MONITOR_PARITY_EN
  task automatic send_frame_badpar(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(~(^b));
    drive_bit(1'b1);
  endtask
`endif

  int unsigned start_cyc;

  initial begin
    rst = 1'b1; rx_i = 1'b1; clear_i = 1'b0; u_if.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // ---- reset state
    check("rst_valid",     32'(u_if.out_valid_o), 32'd0);
    check("rst_data",      32'(u_if.out_data_o),  32'd0);
    check("rst_count",     32'(fifo_count),       32'd0);
    check("rst_busy",      32'(busy),             32'd0);
    check("rst_fe",        32'(frame_err),        32'd0);
    check("rst_fe_cnt",    32'(frame_err_cnt),    32'd0);
    check("rst_ovf",       32'(overflow),         32'd0);
    check("rst_nl",        32'(newline_cnt),      32'd0);
    rst = 1'b0;
    idle_cycles(8);

    // ---- single byte 0x65, consumer always ready
    u_if.out_ready_i = 1'b1;
    start_cyc = cyc;
    send_frame(8'h65, 1'b1);
    idle_cycles(4);
    check("t1_npop",    32'(popq.size()),       32'd1);
    check("t1_data",    32'(popq[0]),           32'h65);
    check("t1_latency", rise_cyc - start_cyc,   32'd307);
    check("t1_busy",    32'(busy),              32'd0);
    check("t1_count",   32'(fifo_count),        32'd0);
    check("t1_fe_cnt",  32'(frame_err_cnt),     32'd0);
    check("t1_fe_puls", fe_pulses,              32'd0);

    // ---- 8-cycle low glitch
    rx_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t2_busy_in", 32'(busy), 32'd1);
    idle_cycles(40);
    check("t2_busy",    32'(busy),          32'd0);
    check("t2_count",   32'(fifo_count),    32'd0);
    check("t2_fe_cnt",  32'(frame_err_cnt), 32'd0);
    check("t2_npop",    32'(popq.size()),   32'd1);

    // ---- bad stop bit, then a good frame
    send_frame(8'hA5, 1'b0);
    idle_cycles(2 * C_CPB);
    check("t3_fe_puls", fe_pulses,           32'd1);
    check("t3_fe_cnt",  32'(frame_err_cnt),  32'd1);
    check("t3_npop",    32'(popq.size()),    32'd1);
    send_frame(8'h5A, 1'b1);
    idle_cycles(4);
    check("t3_npop2",   32'(popq.size()),    32'd2);
    check("t3_data",    32'(popq[1]),        32'h5A);

    // ---- line stuck low: one framing error only
    for (int i = 0; i < 12; i++) drive_bit(1'b0);
    idle_cycles(2 * C_CPB);
    check("t3b_fe_cnt",  32'(frame_err_cnt), 32'd2);
    check("t3b_fe_puls", fe_pulses,          32'd2);
    check("t3b_busy",    32'(busy),          32'd0);

    // ---- 17 back-to-back bytes into a stalled FIFO
    u_if.out_ready_i = 1'b0;
    for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1);
    idle_cycles(8);
    check("t4_count",  32'(fifo_count),      32'd16);
    check("t4_ovf",    32'(overflow),        32'd1);
    check("t4_head",   32'(u_if.out_data_o), 32'h00);
    check("t4_nl",     32'(newline_cnt),     32'd1);
    u_if.out_ready_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t4_npop",   32'(popq.size()),     32'd18);
    for (int i = 0; i < 16; i++) check("t4_drain", 32'(popq[2 + i]), 32'(i));
    check("t4_empty",  32'(fifo_count),      32'd0);
    check("t4_ovf_kp", 32'(overflow),        32'd1);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    check("t4_ovf_clr", 32'(overflow),       32'd0);
    check("t4_fe_clr",  32'(frame_err_cnt),  32'd0);
    check("t4_nl_clr",  32'(newline_cnt),    32'd0);

    // ---- "ok\n\n", then newline push coinciding with clear
    send_frame(8'h6F, 1'b1);
    send_frame(8'h6B, 1'b1);
    send_frame(8'h0A, 1'b1);
    send_frame(8'h0A, 1'b1);
    idle_cycles(4);
    check("t5_nl",   32'(newline_cnt),  32'd2);
    check("t5_npop", 32'(popq.size()),  32'd22);
    fork
      send_frame(8'h0A, 1'b1);
      begin
        repeat (306) @(posedge clk);
        #1 clear_i = 1'b1;
        @(posedge clk);
        #1 clear_i = 1'b0;
      end
    join
    idle_cycles(4);
    check("t5_nl_clr", 32'(newline_cnt), 32'd1);
    check("t5_npop2",  32'(popq.size()), 32'd23);
    check("t5_last",   32'(popq[22]),    32'h0A);

    // ---- reset during data bit 4
    u_if.out_ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    idle_cycles(4);
    check("t6_pre_cnt", 32'(fifo_count), 32'd1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst  = 1'b1;
    rx_i = 1'b1;
    #1;
    check("t6_rst_cnt",  32'(fifo_count),       32'd0);
    check("t6_rst_busy", 32'(busy),             32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2 * C_CPB);
    check("t6_cnt",      32'(fifo_count),       32'd0);
    check("t6_valid",    32'(u_if.out_valid_o), 32'd0);
    check("t6_fe_cnt",   32'(frame_err_cnt),    32'd0);
    check("t6_fe_puls",  fe_pulses,             32'd2);
    u_if.out_ready_i = 1'b1;
    send_frame(8'h38, 1'b1);
    idle_cycles(4);
    check("t6_npop",     32'(popq.size()),      32'd24);
    check("t6_data",     32'(popq[23]),         32'h38);
    check("t6_fe_cnt2",  32'(frame_err_cnt),    32'd0);
    check("t6_ovf",      32'(overflow),         32'd0);

`ifdef UART_RX_MONITOR_PARITY_EN
    // ---- flipped parity: error counted, byte still delivered
    check("t7_pe_pre", 32'(parity_err_cnt), 32'd0);
    send_frame_badpar(8'h38);
    idle_cycles(4);
    check("t7_pe_cnt", 32'(parity_err_cnt), 32'd1);
    check("t7_npop",   32'(popq.size()),    32'd25);
    check("t7_data",   32'(popq[24]),       32'h38);
    check("t7_fe_cnt", 32'(frame_err_cnt),  32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
